// File: rtl/cpu_control_unit.sv
// Two-stage CPU control unit: decode register captures opcode/operands, execute register
// holds the 8-bit ALU result with carry/zero flags and a one-cycle result_valid pulse.
module cpu_control_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   input  logic [18:0] instruction,
   output logic [7:0]  result,
   output logic        result_valid,
   output logic        carry,
   output logic        zero
);

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_INC = 3'b011,
      OP_DEC = 3'b100,
      OP_AND = 3'b101,
      OP_OR  = 3'b110,
      OP_NOT = 3'b111
   } opcode_e;

   logic       s1_valid_q, s1_valid_d;
   opcode_e    s1_op_q, s1_op_d;
   logic [7:0] s1_a_q, s1_a_d;
   logic [7:0] s1_b_q, s1_b_d;

   logic [7:0] result_q, result_d;
   logic       result_valid_q, result_valid_d;
   logic       carry_q, carry_d;
   logic       zero_q, zero_d;

   logic [8:0] alu_wide;

   // Operands only move on a valid instruction so idle-cycle bus contents never reach the ALU.
   always_comb begin
      s1_valid_d = instr_valid;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      if (instr_valid) begin
         s1_op_d = opcode_e'(instruction[18:16]);
         s1_a_d  = instruction[15:8];
         s1_b_d  = instruction[7:0];
      end
   end

   // Bit 8 of the 9-bit result is carry for add/inc and borrow for sub/dec.
   always_comb begin
      alu_wide = 9'd0;
      case (s1_op_q)
         OP_NOP: alu_wide = 9'd0;
         OP_ADD: alu_wide = {1'b0, s1_a_q} + {1'b0, s1_b_q};
         OP_SUB: alu_wide = {1'b0, s1_a_q} - {1'b0, s1_b_q};
         OP_INC: alu_wide = {1'b0, s1_a_q} + 9'd1;
         OP_DEC: alu_wide = {1'b0, s1_a_q} - 9'd1;
         OP_AND: alu_wide = {1'b0, s1_a_q & s1_b_q};
         OP_OR:  alu_wide = {1'b0, s1_a_q | s1_b_q};
         OP_NOT: alu_wide = {1'b0, ~s1_a_q};
      endcase
   end

   always_comb begin
      result_d       = result_q;
      carry_d        = carry_q;
      zero_d         = zero_q;
      result_valid_d = 1'b0;
      if (s1_valid_q && (s1_op_q != OP_NOP)) begin
         result_d       = alu_wide[7:0];
         carry_d        = alu_wide[8];
         zero_d         = (alu_wide[7:0] == 8'h00);
         result_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q     <= 1'b0;
         s1_op_q        <= OP_NOP;
         s1_a_q         <= 8'h00;
         s1_b_q         <= 8'h00;
         result_q       <= 8'h00;
         result_valid_q <= 1'b0;
         carry_q        <= 1'b0;
         zero_q         <= 1'b0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_op_q        <= s1_op_d;
         s1_a_q         <= s1_a_d;
         s1_b_q         <= s1_b_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         carry_q        <= carry_d;
         zero_q         <= zero_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign carry        = carry_q;
   assign zero         = zero_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized and directed bench for cpu_control_unit against an arithmetic reference model
// that predicts each instruction's outputs one cycle after it is captured.
module tb_cpu_control_unit;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic [18:0] instruction;
   logic [7:0]  result;
   logic        result_valid;
   logic        carry;
   logic        zero;

   int n_vec;
   int n_err;
   int n_txn;

   // Reference state: architectural outputs plus the instruction captured last cycle.
   int m_res, m_c, m_z, m_rv;
   int prev_v, prev_op, prev_a, prev_b;

   logic [7:0] obs_q[$];

   cpu_control_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instruction  (instruction),
      .result       (result),
      .result_valid (result_valid),
      .carry        (carry),
      .zero         (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
      end
   endtask

   task automatic model_reset();
      m_res = 0; m_c = 0; m_z = 0; m_rv = 0;
      prev_v = 0; prev_op = 0; prev_a = 0; prev_b = 0;
   endtask

   // Retire the previously captured instruction into the expected outputs.
   task automatic model_execute();
      int r;
      int c;
      m_rv = 0;
      if (prev_v != 0 && prev_op != 0) begin
         r = 0;
         c = 0;
         case (prev_op)
            1: begin r = prev_a + prev_b;  c = (r > 255) ? 1 : 0; end
            2: begin r = prev_a - prev_b;  c = (prev_a < prev_b) ? 1 : 0; end
            3: begin r = prev_a + 1;       c = (prev_a == 255) ? 1 : 0; end
            4: begin r = prev_a - 1;       c = (prev_a == 0) ? 1 : 0; end
            5: r = prev_a & prev_b;
            6: r = prev_a | prev_b;
            default: r = 255 - prev_a;
         endcase
         r = (r + 256) % 256;
         m_res = r;
         m_c   = c;
         m_z   = (r == 0) ? 1 : 0;
         m_rv  = 1;
      end
   endtask

   task automatic check_outputs(input string where);
      check_eq({where, ".result"},       {24'd0, result},       m_res);
      check_eq({where, ".result_valid"}, {31'd0, result_valid}, m_rv);
      check_eq({where, ".carry"},        {31'd0, carry},        m_c);
      check_eq({where, ".zero"},         {31'd0, zero},         m_z);
   endtask

   // Drive one instruction, let one edge pass, then compare outputs on the falling edge.
   task automatic do_cycle(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [18:0] w;
      w = v ? {op, a, b} : 19'($urandom);
      instr_valid = v;
      instruction = w;
      @(posedge clk);
      @(negedge clk);
      n_txn++;
      model_execute();
      check_outputs("cyc");
      if (result_valid === 1'b1) obs_q.push_back(result);
      $display("txn %0d: in v=%0b op=%0d a=%02h b=%02h | out rv=%0b res=%02h c=%0b z=%0b",
               n_txn, v, op, a, b, result_valid, result, carry, zero);
      prev_v  = v;
      prev_op = int'(w[18:16]);
      prev_a  = int'(w[15:8]);
      prev_b  = int'(w[7:0]);
   endtask

   initial begin
      logic [7:0] exp_seq [7];
      logic [7:0] ra, rb;
      n_vec = 0; n_err = 0; n_txn = 0;
      exp_seq = '{8'h37, 8'h0F, 8'h24, 8'h22, 8'h00, 8'h37, 8'hDC};

      rst_n = 1'b0;
      instr_valid = 1'b0;
      instruction = 19'd0;
      model_reset();
      #3;
      check_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Reference operand pair through all seven ops, back to back.
      do_cycle(0, 3'd0, 8'h00, 8'h00);
      obs_q.delete();
      for (int op = 1; op <= 7; op++) do_cycle(1, 3'(op), 8'h23, 8'h14);
      do_cycle(0, 3'd0, 8'h00, 8'h00);
      check_eq("seq.count", obs_q.size(), 7);
      for (int i = 0; i < 7; i++) begin
         if (i < obs_q.size()) check_eq("seq.order", {24'd0, obs_q[i]}, {24'd0, exp_seq[i]});
      end

      // Wrap-around boundaries, each followed by NOP and idle hold cycles.
      do_cycle(1, 3'd1, 8'hFF, 8'h01);
      do_cycle(1, 3'd0, 8'h55, 8'hAA);
      do_cycle(1, 3'd3, 8'hFF, 8'h77);
      do_cycle(0, 3'd0, 8'h00, 8'h00);
      do_cycle(1, 3'd2, 8'h00, 8'h01);
      do_cycle(1, 3'd4, 8'h00, 8'h99);
      do_cycle(0, 3'd0, 8'h00, 8'h00);
      check_eq("dec00.result", {24'd0, result}, 32'hFF);
      check_eq("dec00.carry",  {31'd0, carry},  32'd1);
      do_cycle(0, 3'd0, 8'h00, 8'h00);

      // Asynchronous reset with an ADD sitting in the decode stage.
      do_cycle(1, 3'd6, 8'h5A, 8'h01);
      do_cycle(1, 3'd1, 8'h10, 8'h20);
      instr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge clk);
      @(negedge clk);
      check_outputs("in_rst");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) do_cycle(0, 3'd0, 8'h00, 8'h00);

      // Random traffic with biased corner operands.
      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h01;
         do_cycle($urandom_range(0, 3) != 0, 3'($urandom), ra, rb);
      end
      do_cycle(0, 3'd0, 8'h00, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
